// File: rtl/ram_hs_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asyncarm_mem_pkg
// Brief    : Shared types and constants for the memory-side handshake
//            responders (RAM now, ROM later).
// Revision : 1.0 - initial release
// ============================================================================
package asyncarm_mem_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int          WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage : asyncarm_mem_pkg
`default_nettype wire

// File: rtl/ram_hs_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_hs_responder_if
// Brief    : Four-phase trigger/ready data-memory bus between the CPU
//            (master) and the memory responder (slave).
//            errOut exists only when RAM_RANGE_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_hs_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addrIn;
    logic [DATA_W-1:0] dataIn;
    logic              rwIn;
    logic              triggerIn;
    logic [DATA_W-1:0] dataOut;
    logic              readyOut;
`ifdef RAM_RANGE_ERR_EN
    logic              errOut;
`endif

    // CPU side: drives the request, observes the acknowledge
    modport master (
        output addrIn, dataIn, rwIn, triggerIn,
`ifdef RAM_RANGE_ERR_EN
        input  errOut,
`endif
        input  dataOut, readyOut
    );

    // Memory side: observes the request, drives the acknowledge
    modport slave (
        input  addrIn, dataIn, rwIn, triggerIn,
`ifdef RAM_RANGE_ERR_EN
        output errOut,
`endif
        output dataOut, readyOut
    );

endinterface : ram_hs_responder_if
`default_nettype wire

// File: rtl/ram_hs_responder_hs_sync.sv
`default_nettype none
// ============================================================================
// Module   : hs_sync
// Brief    : SYNC_STAGES-deep flop chain bringing an asynchronous handshake
//            line into the clk domain. Cleared by reset. Shared with the
//            ROM responder.
// Revision : 1.0 - initial release
// ============================================================================
module hs_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic async_in,
    output logic      sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule : hs_sync
`default_nettype wire

// File: rtl/ram_hs_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_hs_responder
// Brief    : Clocked RAM answering the CPU's four-phase trigger/ready data
//            handshake. Synchronises the trigger, waits WAIT_CYCLES, does a
//            single-cycle read or write, then holds readyOut until the
//            trigger is seen low.
//            Optional feature macro: RAM_RANGE_ERR_EN (out-of-range accesses
//            flagged on errOut, writes suppressed, reads return ERR_DATA).
// Revision : 1.0 - initial release
// ============================================================================
module ram_hs_responder
    import asyncarm_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ram_hs_responder_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(1);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    trig_s;
    logic                    trig_q;
    logic                    ready_r;
    logic [DATA_W-1:0]       data_r;
    logic                    in_range;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [DATA_W-1:0]       mem [0:DEPTH-1];

    hs_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.triggerIn),
        .sync_out (trig_s)
    );

    // Byte address to word index; the two low bits are ignored
    assign word_idx = bus.addrIn[DEPTH_LOG2+1:2];

`ifdef RAM_RANGE_ERR_EN
    logic err_r;
    assign in_range   = (bus.addrIn[ADDR_W-1:DEPTH_LOG2+2] == '0);
    assign bus.errOut = err_r;
`else
    // Upper address bits alias modulo DEPTH
    assign in_range = 1'b1;
`endif

    assign mem_we       = (state == ACCESS) && (bus.rwIn == RW_WRITE) && in_range;
    assign bus.readyOut = ready_r;
    assign bus.dataOut  = data_r;

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= bus.dataIn;
        end
    end

    // Handshake FSM with registered ready/data/err outputs. Release looks at
    // the synchronised trigger one flop later, so readyOut falls
    // SYNC_STAGES+1 edges after the trigger is first sampled low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            trig_q   <= 1'b0;
            ready_r  <= 1'b0;
            data_r   <= '0;
`ifdef RAM_RANGE_ERR_EN
            err_r    <= 1'b0;
`endif
        end else begin
            trig_q <= trig_s;
            case (state)
                IDLE: begin
                    if (trig_s) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_LAST;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.rwIn == RW_READ) begin
                        data_r <= in_range ? mem[word_idx] : DATA_W'(ERR_DATA);
                    end
`ifdef RAM_RANGE_ERR_EN
                    err_r   <= ~in_range;
`endif
                    ready_r <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (!trig_q) begin
                        ready_r <= 1'b0;
`ifdef RAM_RANGE_ERR_EN
                        err_r   <= 1'b0;
`endif
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ram_hs_responder
`default_nettype wire
